// File: rtl/mem_bus_arbiter.sv
// Purpose : shares one single-ported memory bus between the core's ROM (fetch) and RAM (load/store) ports.
// Latency : stalls the core from the request cycle; zero-wait bus gives 3 cycles per advance for one port, 4 for both.
// Backpr. : mem_req is held until mem_ready; each wait cycle adds one stall cycle. Optional counters: MEM_BUS_ARB_PERF_EN.
`timescale 1ns/1ps
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SEL_WIDTH     = 4,
    parameter int DATA_PRIORITY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rom_en,
    input  logic [SEL_WIDTH-1:0]  rom_write_en,
    input  logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_write_data,
    output logic [DATA_WIDTH-1:0] rom_read_data,
    input  logic                  ram_en,
    input  logic [SEL_WIDTH-1:0]  ram_write_en,
    input  logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_write_data,
    output logic [DATA_WIDTH-1:0] ram_read_data,
    output logic                  stall,
    output logic                  mem_req,
    output logic [SEL_WIDTH-1:0]  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
`ifdef MEM_BUS_ARB_PERF_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_bus_txns
`endif
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DATA_REQ = 2'd1;
    localparam logic [1:0] INST_REQ = 2'd2;
    localparam logic [1:0] RELEASE  = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic                  rom_served;
    logic                  ram_served;
    logic [DATA_WIDTH-1:0] rom_buf;
    logic [DATA_WIDTH-1:0] ram_buf;
    logic                  accept;

    // mem_ready only counts while a request is actually on the bus
    assign accept = mem_ready && ((state == DATA_REQ) || (state == INST_REQ));

    // next-state: pick the first port by priority, then chain to the other port if it still needs service
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ram_en && (!rom_en || (DATA_PRIORITY != 0)))
                    state_nxt = DATA_REQ;
                else if (rom_en)
                    state_nxt = INST_REQ;
                else
                    state_nxt = IDLE;
            end
            DATA_REQ: begin
                if (mem_ready)
                    state_nxt = (rom_en && !rom_served) ? INST_REQ : RELEASE;
            end
            INST_REQ: begin
                if (mem_ready)
                    state_nxt = (ram_en && !ram_served) ? DATA_REQ : RELEASE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // per-round served flags; cleared on the way back to IDLE so the next round starts fresh
    always_ff @(posedge clk) begin
        if (rst || (state == RELEASE)) begin
            rom_served <= 1'b0;
            ram_served <= 1'b0;
        end else if (accept) begin
            if (state == DATA_REQ) ram_served <= 1'b1;
            if (state == INST_REQ) rom_served <= 1'b1;
        end
    end

    // read-data buffers: capture only on a completed read, so stores leave them untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_buf <= '0;
            ram_buf <= '0;
        end else if (accept && (mem_we == '0)) begin
            if (state == DATA_REQ) ram_buf <= mem_rdata;
            if (state == INST_REQ) rom_buf <= mem_rdata;
        end
    end

    assign rom_read_data = rom_buf;
    assign ram_read_data = ram_buf;

    // bus drive and stall: the core holds its request stable while stalled, so muxing it through is stable too
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        stall     = 1'b0;
        case (state)
            IDLE: stall = rom_en | ram_en;
            DATA_REQ: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = ram_write_en;
                mem_addr  = ram_addr;
                mem_wdata = ram_write_data;
            end
            INST_REQ: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = rom_write_en;
                mem_addr  = rom_addr;
                mem_wdata = rom_write_data;
            end
            default: stall = 1'b0;
        endcase
    end

`ifdef MEM_BUS_ARB_PERF_EN
    // saturating counters for stalled cycles and completed bus transactions
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_bus_txns     <= '0;
        end else begin
            if (stall && (perf_stall_cycles != 32'hFFFF_FFFF))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (accept && (perf_bus_txns != 32'hFFFF_FFFF))
                perf_bus_txns <= perf_bus_txns + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Purpose : directed checks of mem_bus_arbiter with both port priorities side by side.
// Latency : checks sampled 1 ns after the rising edge, inputs driven from the initial block.
// Backpr. : a small responder task inserts a chosen number of mem_ready wait cycles.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_en, ram_en;
    logic [3:0]  rom_write_en, ram_write_en;
    logic [31:0] rom_addr, ram_addr, rom_write_data, ram_write_data;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        sel;

    logic [31:0] rom_rd_a, ram_rd_a, addr_a, wdata_a, rom_rd_b, ram_rd_b, addr_b, wdata_b;
    logic        stall_a, req_a, stall_b, req_b;
    logic [3:0]  we_a, we_b;
    logic        ready_a, ready_b;
`ifdef MEM_BUS_ARB_PERF_EN
    logic [31:0] perf_stall_a, perf_txns_a, perf_stall_b, perf_txns_b;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // sel picks which instance the bench is talking to
    assign ready_a = sel ? 1'b0 : mem_ready;
    assign ready_b = sel ? mem_ready : 1'b0;

    logic [31:0] rom_rd, ram_rd, m_addr, m_wdata;
    logic        m_stall, m_req;
    logic [3:0]  m_we;
    assign rom_rd  = sel ? rom_rd_b : rom_rd_a;
    assign ram_rd  = sel ? ram_rd_b : ram_rd_a;
    assign m_addr  = sel ? addr_b   : addr_a;
    assign m_wdata = sel ? wdata_b  : wdata_a;
    assign m_stall = sel ? stall_b  : stall_a;
    assign m_req   = sel ? req_b    : req_a;
    assign m_we    = sel ? we_b     : we_a;

    mem_bus_arbiter #(.DATA_PRIORITY(1)) dut_a (
        .clk(clk), .rst(rst),
        .rom_en(rom_en), .rom_write_en(rom_write_en), .rom_addr(rom_addr),
        .rom_write_data(rom_write_data), .rom_read_data(rom_rd_a),
        .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
        .ram_write_data(ram_write_data), .ram_read_data(ram_rd_a),
        .stall(stall_a), .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a),
        .mem_wdata(wdata_a), .mem_rdata(mem_rdata), .mem_ready(ready_a)
`ifdef MEM_BUS_ARB_PERF_EN
        , .perf_stall_cycles(perf_stall_a), .perf_bus_txns(perf_txns_a)
`endif
    );

    mem_bus_arbiter #(.DATA_PRIORITY(0)) dut_b (
        .clk(clk), .rst(rst),
        .rom_en(rom_en), .rom_write_en(rom_write_en), .rom_addr(rom_addr),
        .rom_write_data(rom_write_data), .rom_read_data(rom_rd_b),
        .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
        .ram_write_data(ram_write_data), .ram_read_data(ram_rd_b),
        .stall(stall_b), .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b),
        .mem_wdata(wdata_b), .mem_rdata(mem_rdata), .mem_ready(ready_b)
`ifdef MEM_BUS_ARB_PERF_EN
        , .perf_stall_cycles(perf_stall_b), .perf_bus_txns(perf_txns_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rom_en = 0; ram_en = 0; rom_write_en = 0; ram_write_en = 0;
        rom_addr = 0; ram_addr = 0; rom_write_data = 0; ram_write_data = 0;
        mem_rdata = 0; mem_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h0000_0100)      return 32'hCAFE_0001;
        else if (a == 32'h0000_0000) return 32'h2402_0007;
        else                         return 32'hDEAD_BEEF;
    endfunction

    // Runs one arbitration round: answers every bus request after 'waits' cycles,
    // returns the number of stalled cycles and the first request's address/we/wdata.
    task automatic run_round(input int waits, output int stalls, output logic [31:0] first_addr,
                             output logic [3:0] first_we, output logic [31:0] first_wdata);
        int  wcnt = 0;
        bit  seen = 0;
        bit  done = 0;
        stalls = 0; first_addr = 'x; first_we = 'x; first_wdata = 'x;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (!m_stall) begin
                done = 1;
                break;
            end
            stalls++;
            mem_ready = 1'b0;
            if (m_req) begin
                if (!seen) begin
                    first_addr = m_addr; first_we = m_we; first_wdata = m_wdata; seen = 1;
                end
                if (wcnt == waits) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_model(m_addr);
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
            @(posedge clk);
        end
        chk("round_timeout", {31'd0, done}, 32'd1);
        mem_ready = 1'b0;
    endtask

    task automatic finish_round();
        rom_en = 0; ram_en = 0; ram_write_en = 0;
        @(posedge clk); #1;
    endtask

    int          st;
    logic [31:0] fa, fw;
    logic [3:0]  fwe;

    initial begin
        sel = 1'b0;
        // reset state
        do_reset();
        #1;
        chk("rst_stall", {31'd0, m_stall}, 32'd0);
        chk("rst_req", {31'd0, m_req}, 32'd0);
        chk("rst_addr", m_addr, 32'd0);
        chk("rst_rom_rd", rom_rd, 32'd0);
        chk("rst_ram_rd", ram_rd, 32'd0);

        // 1: single fetch, zero wait, mem_ready already high in IDLE
        @(posedge clk); #1;
        rom_en = 1; rom_addr = 32'h0; mem_ready = 1; mem_rdata = 32'h2401_0005;
        #1;
        chk("t1_idle_stall", {31'd0, m_stall}, 32'd1);
        chk("t1_idle_req", {31'd0, m_req}, 32'd0);
        @(posedge clk); #1;
        chk("t1_req_stall", {31'd0, m_stall}, 32'd1);
        chk("t1_req", {31'd0, m_req}, 32'd1);
        chk("t1_req_addr", m_addr, 32'h0);
        chk("t1_ready_ignored_in_idle", rom_rd, 32'd0);
        @(posedge clk); #1;
        chk("t1_rel_stall", {31'd0, m_stall}, 32'd0);
        chk("t1_rel_req", {31'd0, m_req}, 32'd0);
        chk("t1_rom_rd", rom_rd, 32'h2401_0005);
        mem_ready = 0; rom_en = 0;
        @(posedge clk); #1;
        chk("t1_idle_after", {31'd0, m_stall}, 32'd0);

        // 2: both ports, two wait cycles each, data first
        rom_en = 1; rom_addr = 32'h0; ram_en = 1; ram_addr = 32'h100; ram_write_en = 0;
        run_round(2, st, fa, fwe, fw);
        chk("t2_first_addr", fa, 32'h100);
        chk("t2_stalls", st, 32'd7);
        chk("t2_ram_rd", ram_rd, 32'hCAFE_0001);
        chk("t2_rom_rd", rom_rd, 32'h2402_0007);
        chk("t2_rel_req", {31'd0, m_req}, 32'd0);
        finish_round();

        // 3: instruction-first instance, same stimulus
        do_reset();
        sel = 1'b1;
        #1;
        rom_en = 1; rom_addr = 32'h0; ram_en = 1; ram_addr = 32'h100; ram_write_en = 0;
        run_round(2, st, fa, fwe, fw);
        chk("t3_first_addr", fa, 32'h0);
        chk("t3_stalls", st, 32'd7);
        chk("t3_ram_rd", ram_rd, 32'hCAFE_0001);
        chk("t3_rom_rd", rom_rd, 32'h2402_0007);
        finish_round();

        // 4: load to fill the buffer, then a store must not disturb it
        do_reset();
        sel = 1'b0;
        #1;
        ram_en = 1; ram_addr = 32'h100; ram_write_en = 0;
        run_round(0, st, fa, fwe, fw);
        chk("t4_load_stalls", st, 32'd2);
        chk("t4_load_rd", ram_rd, 32'hCAFE_0001);
        finish_round();
        ram_en = 1; ram_addr = 32'h10; ram_write_en = 4'b0011; ram_write_data = 32'h0000_BEEF;
        run_round(0, st, fa, fwe, fw);
        chk("t4_store_we", {28'd0, fwe}, 32'h3);
        chk("t4_store_addr", fa, 32'h10);
        chk("t4_store_wdata", fw, 32'h0000_BEEF);
        chk("t4_store_no_capture", ram_rd, 32'hCAFE_0001);
        finish_round();

        // 5: reset while a data request is waiting for mem_ready
        ram_en = 1; ram_addr = 32'h100; ram_write_en = 0;
        @(posedge clk); #1;
        chk("t5_in_req", {31'd0, m_req}, 32'd1);
        rst = 1; ram_en = 0;
        @(posedge clk); #1;
        chk("t5_req_dropped", {31'd0, m_req}, 32'd0);
        chk("t5_stall", {31'd0, m_stall}, 32'd0);
        chk("t5_ram_cleared", ram_rd, 32'd0);
        rst = 0;
        @(posedge clk); #1;

`ifdef MEM_BUS_ARB_PERF_EN
        // 6: counters over two dual-port rounds with two wait cycles each
        do_reset();
        sel = 1'b0;
        #1;
        chk("t6_perf_rst", perf_txns_a, 32'd0);
        for (int r = 0; r < 2; r++) begin
            rom_en = 1; rom_addr = 32'h0; ram_en = 1; ram_addr = 32'h100; ram_write_en = 0;
            run_round(2, st, fa, fwe, fw);
            finish_round();
        end
        chk("t6_perf_txns", perf_txns_a, 32'd4);
        chk("t6_perf_stalls", perf_stall_a, 32'd14);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
